dp_ram_fifo_ctrl: RTL
=====================

// Module: dp_ram_fifo_ctrl
// PURPOSE
//  Valid/ready FIFO controller that drives the dual-port RAM (write port A, registered read port B).
//  Owns the write/read pointers and full/empty tracking.
//  Prefetches words into a 2-entry output buffer, giving first-word-fall-through output at full throughput.
//  Sits between a streaming producer and a streaming consumer; the RAM is instantiated alongside it at the same level.
// PARAMETERS
//  DATA_WIDTH  8   word width; must match the RAM
//  DEPTH       16  RAM entries; power of two, >=2
//  AW (localparam) = $clog2(DEPTH); LW (localparam) = $clog2(DEPTH+3)
// PORTS
//  Clk        in   1           clock; everything is rising-edge
//  Rst        in   1           asynchronous, active-high reset
//  clr        in   1           synchronous flush
//  in_valid   in   1           producer word valid
//  in_ready   out  1           controller can accept a word
//  in_data    in   DATA_WIDTH  producer word
//  out_valid  out  1           out_data valid
//  out_ready  in   1           consumer accepts out_data
//  out_data   out  DATA_WIDTH  head-of-FIFO word
//  ram_we     out  1           RAM write enable
//  ram_waddr  out  AW          RAM port-A address
//  ram_wdata  out  DATA_WIDTH  RAM port-A data
//  ram_raddr  out  AW          RAM port-B address; data returns on ram_rdata one cycle later
//  ram_rdata  in   DATA_WIDTH  RAM registered read data
//  level      out  LW          total words held: RAM + in-flight read + output buffer
// BEHAVIOUR
//  Reset (Rst=1, async):
//   - wr_ptr/rd_ptr = 0, each AW+1 bits with a wrap bit
//   - rd_pend = 0, obuf empty
//   - in_ready=0, out_valid=0, out_data=0, ram_we=0, level=0
//   - in_ready rises the first cycle after Rst deasserts
//  Push: push = in_valid & in_ready.
//   - ram_we = push (combinational); ram_waddr = wr_ptr[AW-1:0]; ram_wdata = in_data
//   - wr_ptr increments on push
//  RAM occupancy: ram_cnt = wr_ptr - rd_ptr (AW+1 bits, wrap-safe).
//   - in_ready = (ram_cnt != DEPTH), computed from registered state only
//   - No push when full, even if a read issues in the same cycle
//  Read issue: rd_issue = (ram_cnt != 0) & (obuf_cnt + rd_pend - pop < 2), where pop = out_valid & out_ready.
//   - ram_raddr = rd_ptr[AW-1:0]
//   - On rd_issue: rd_ptr++ and rd_pend <= 1; otherwise rd_pend <= 0
//   - When rd_pend=1, ram_rdata is written into the obuf that cycle
//  Read-after-write: a word written at edge N can be issued no earlier than cycle N+1, because ram_cnt updates at edge N.
//   - Port A and port B never address the same new word in one cycle
//  Output buffer: 2-entry FIFO; out_valid = (obuf_cnt != 0); out_data = head entry.
//   - Simultaneous load and pop is allowed
//  Latency: word accepted in cycle N -> out_valid in cycle N+3 when the FIFO was empty.
//   - Sustained throughput is 1 word/cycle with out_ready held high
//  Capacity and level:
//   - Capacity = DEPTH+2 words
//   - level = ram_cnt + rd_pend + obuf_cnt, registered, never exceeds DEPTH+2
//  clr=1 (takes priority over push/pop/issue):
//   - Pointers, rd_pend and obuf go to 0; out_valid=0 and level=0 next cycle
//   - ram_we is forced to 0 while clr=1
//   - Any ram_rdata returning the cycle after clr is discarded
//  Wrap-around: pointers roll from 2*DEPTH-1 to 0; full/empty are resolved by the wrap bit.
//  A data-less pop (out_ready with out_valid=0) is ignored.
//  RAM contents are never cleared; stale data is unreachable by construction.
// STRUCTURE
//  No shared package; no typedefs. AW/LW are local localparams, derived from DEPTH only.
//  One sub-module: fifo_obuf (2-entry output skid buffer; ports Clk, Rst, clr, load, load_data, pop, cnt, head).
//  Pointer/issue logic stays in the top module.
// TESTING
//  Reset: Rst pulsed mid-stream with level=7 -> all outputs 0 immediately; in_ready=1 one cycle after release.
//  Latency: DEPTH=16, single push 0xA5 at cycle 0 -> out_valid=1 and out_data=0xA5 at cycle 3; level 1 from cycle 1.
//  Fill: 18 pushes with out_ready=0 -> in_ready=0 after the 18th; level=18; the 19th push is stalled.
//   - Then out_ready=1 -> data 0..17 out in order.
//  Streaming: in_valid=out_ready=1 for 100 cycles, incrementing data -> one word/cycle after fill.
//   - Order preserved across 6 pointer wraps; level constant.
//  Backpressure: random out_ready (50%) and random in_valid -> scoreboard matches.
//   - level never exceeds 18; no obuf overflow; ram_we never asserted while in_ready=0.
//  Flush: clr during an in-flight read (rd_pend=1) with level=5 -> next cycle out_valid=0, level=0.
//   - The next push 0x3C is the first word out.

Source files
------------

// File: rtl/dp_ram_fifo_ctrl_obuf.sv
// fifo_obuf: two-entry output skid buffer sitting on the RAM read port.
// Entry e0 is always the head, so out_data comes straight from a flop.
module fifo_obuf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  clr,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  pop,
  output logic [1:0]            cnt,
  output logic [DATA_WIDTH-1:0] head
);

  logic [1:0]            cnt_r;
  logic [DATA_WIDTH-1:0] e0_r;
  logic [DATA_WIDTH-1:0] e1_r;
  logic                  pop_s;
  logic                  load_s;

  // A pop with nothing held is ignored; a load into a full buffer is only taken alongside a pop.
  always_comb begin
    pop_s  = pop & (cnt_r != 2'd0);
    load_s = load & ((cnt_r != 2'd2) | pop_s);
  end

  // Shift-register storage with head in e0.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt_r <= 2'd0;
      e0_r  <= '0;
      e1_r  <= '0;
    end else if (clr) begin
      cnt_r <= 2'd0;
    end else begin
      case ({load_s, pop_s})
        2'b10: begin
          if (cnt_r == 2'd0) e0_r <= load_data;
          else               e1_r <= load_data;
          cnt_r <= cnt_r + 2'd1;
        end
        2'b01: begin
          e0_r  <= e1_r;
          cnt_r <= cnt_r - 2'd1;
        end
        2'b11: begin
          if (cnt_r == 2'd1) begin
            e0_r <= load_data;
          end else begin
            e0_r <= e1_r;
            e1_r <= load_data;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign cnt  = cnt_r;
  assign head = e0_r;

endmodule

// File: rtl/dp_ram_fifo_ctrl.sv
// dp_ram_fifo_ctrl: valid/ready FIFO controller for an external dual-port RAM
// (write port A, registered read port B) with a 2-entry prefetch buffer for FWFT output.
module dp_ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          clr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          ram_we,
  output logic [$clog2(DEPTH)-1:0]      ram_waddr,
  output logic [DATA_WIDTH-1:0]         ram_wdata,
  output logic [$clog2(DEPTH)-1:0]      ram_raddr,
  input  logic [DATA_WIDTH-1:0]         ram_rdata,
  output logic [$clog2(DEPTH+3)-1:0]    level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 3);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic          rd_pend_r;
  logic          ready_en_r;
  logic [LW-1:0] level_r;

  logic [AW:0]   ram_cnt_s;
  logic [1:0]    obuf_cnt_s;
  logic [2:0]    obuf_room_s;
  logic          push_s;
  logic          pop_s;
  logic          rd_issue_s;
  logic          load_s;
  logic          out_valid_s;

  // Handshake and read-issue decisions; the buffer may take a new read only if it will have space when data returns.
  always_comb begin
    ram_cnt_s   = wr_ptr_r - rd_ptr_r;
    in_ready    = ready_en_r & (ram_cnt_s != FULL_CNT);
    out_valid_s = (obuf_cnt_s != 2'd0);
    pop_s       = out_valid_s & out_ready;
    push_s      = in_valid & in_ready & ~clr;
    obuf_room_s = {1'b0, obuf_cnt_s} + {2'b00, rd_pend_r} - {2'b00, pop_s};
    rd_issue_s  = (ram_cnt_s != '0) & (obuf_room_s < 3'd2) & ~clr;
    load_s      = rd_pend_r & ~clr;
  end

  // Pointers, in-flight read flag, post-reset ready enable and the occupancy count.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      rd_pend_r  <= 1'b0;
      ready_en_r <= 1'b0;
      level_r    <= '0;
    end else begin
      ready_en_r <= 1'b1;
      if (clr) begin
        wr_ptr_r  <= '0;
        rd_ptr_r  <= '0;
        rd_pend_r <= 1'b0;
        level_r   <= '0;
      end else begin
        if (push_s)     wr_ptr_r <= wr_ptr_r + (AW + 1)'(1);
        if (rd_issue_s) rd_ptr_r <= rd_ptr_r + (AW + 1)'(1);
        rd_pend_r <= rd_issue_s;
        level_r   <= level_r + LW'(push_s) - LW'(pop_s);
      end
    end
  end

  fifo_obuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_obuf (
    .Clk       (Clk),
    .Rst       (Rst),
    .clr       (clr),
    .load      (load_s),
    .load_data (ram_rdata),
    .pop       (pop_s),
    .cnt       (obuf_cnt_s),
    .head      (out_data)
  );

  assign out_valid = out_valid_s;
  assign ram_we    = push_s;
  assign ram_waddr = wr_ptr_r[AW-1:0];
  assign ram_wdata = in_data;
  assign ram_raddr = rd_ptr_r[AW-1:0];
  assign level     = level_r;

endmodule
